// File: rtl/mpmac_mix.sv
// Multi-channel signed multiply-accumulate for the mixer: sums NCH sample x gain
// products per frame, then rescales, optionally rounds and saturates to one output sample.
module mpmac_mix #(
  parameter int MPCAND_W = 24,
  parameter int MPLIER_W = 16,
  parameter int NCH      = 4,
  parameter int FRAC_W   = 15,
  parameter int OUT_W    = 24,
  parameter int ROUND    = 1
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  input  logic                       sof_i,
  input  logic signed [MPCAND_W-1:0] mpcand_i,
  input  logic signed [MPLIER_W-1:0] mplier_i,
  output logic signed [OUT_W-1:0]    mprod_o,
  output logic                       valid_o,
  output logic                       sat_o,
  output logic                       err_o
);

  localparam int PROD_W = MPCAND_W + MPLIER_W;
  localparam int ACC_W  = PROD_W + $clog2(NCH) + 1;
  localparam int CNT_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NCH - 1);
  localparam logic [ACC_W:0]   RND_K   =
    (ROUND != 0 && FRAC_W > 0) ? ((ACC_W+1)'(1) << (FRAC_W - 1)) : '0;

  // One guard bit above the accumulator so the rounding offset can never wrap.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    sum = {acc[ACC_W-1], acc};
    sum = sum + $signed(RND_K);
    return sum >>> FRAC_W;
  endfunction

  // Returns {clipped, value}; in range when all bits above the output sign bit agree.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] s);
    if ((&s[ACC_W:OUT_W-1]) || !(|s[ACC_W:OUT_W-1]))
      return {1'b0, s[OUT_W-1:0]};
    else if (s[ACC_W])
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           ch;
  logic                       vld_p0, first_p0, last_p0;
  logic                       vld_p1, first_p1, last_p1;
  logic                       vld_p2;
  logic signed [MPCAND_W-1:0] a_p0;
  logic signed [MPLIER_W-1:0] b_p0;
  logic signed [PROD_W-1:0]   prod_p1;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_p2;

  assign ch       = sof_i ? '0 : cnt;
  assign prod_ext = {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};

  // Stage p0: operand capture, channel tracking and abort detection.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      vld_p0   <= valid_i;
      first_p0 <= valid_i && (ch == '0);
      last_p0  <= valid_i && (ch == LAST_CH);
      if (valid_i) begin
        cnt <= (ch == LAST_CH) ? '0 : ch + CNT_W'(1);
        if (sof_i && cnt != '0)
          err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      a_p0 <= mpcand_i;
      b_p0 <= mplier_i;
    end
  end

  // Stage p1: full-precision product.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0)
      prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
  end

  // Stage p2: accumulate; channel 0 restarts the sum, which also drops an aborted frame.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 && last_p1;
      if (vld_p1)
        acc_p2 <= first_p1 ? prod_ext : acc_p2 + prod_ext;
    end
  end

  // Stage p3: rescale, round, saturate and hold the result until the next frame.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mprod_o <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= vld_p2;
      if (vld_p2)
        {sat_o, mprod_o} <= saturate(round_shift(acc_p2));
    end
  end

endmodule

// File: tb/tb_mpmac_mix.sv
// Randomised and directed scoreboard bench for mpmac_mix against a plain-arithmetic frame model.
module tb_mpmac_mix;
  localparam int MPCAND_W = 24;
  localparam int MPLIER_W = 16;
  localparam int NCH      = 4;
  localparam int FRAC_W   = 15;
  localparam int OUT_W    = 24;
  localparam int ROUND    = 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic valid_i = 1'b0;
  logic sof_i = 1'b0;
  logic signed [MPCAND_W-1:0] mpcand_i = '0;
  logic signed [MPLIER_W-1:0] mplier_i = '0;
  logic signed [OUT_W-1:0]    mprod_o;
  logic valid_o, sat_o, err_o;

  mpmac_mix #(
    .MPCAND_W(MPCAND_W), .MPLIER_W(MPLIER_W), .NCH(NCH),
    .FRAC_W(FRAC_W), .OUT_W(OUT_W), .ROUND(ROUND)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .valid_i(valid_i), .sof_i(sof_i),
    .mpcand_i(mpcand_i), .mplier_i(mplier_i),
    .mprod_o(mprod_o), .valid_o(valid_o), .sat_o(sat_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    bit     sat;
    int     at;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     m_cnt = 0;
  longint m_sum = 0;
  bit     m_err = 1'b0;

  localparam longint OMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OUT_W - 1));
  localparam longint AMAX = (longint'(1) <<< (MPCAND_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (MPCAND_W - 1));
  localparam longint BMAX = (longint'(1) <<< (MPLIER_W - 1)) - 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the frame model for an accepted pair.
  task automatic issue(input bit v, input bit s, input longint a, input longint b);
    int     ch;
    longint sh;
    exp_t   e;
    @(negedge clk);
    valid_i  = v;
    sof_i    = s;
    mpcand_i = MPCAND_W'(a);
    mplier_i = MPLIER_W'(b);
    if (v) begin
      if (s && m_cnt != 0) m_err = 1'b1;
      ch = s ? 0 : m_cnt;
      m_sum = (ch == 0) ? a * b : m_sum + a * b;
      if (ch == NCH - 1) begin
        sh = (m_sum + (ROUND != 0 ? (longint'(1) <<< (FRAC_W - 1)) : 0)) >>> FRAC_W;
        if (sh > OMAX)      begin e.val = OMAX; e.sat = 1'b1; end
        else if (sh < OMIN) begin e.val = OMIN; e.sat = 1'b1; end
        else                begin e.val = sh;   e.sat = 1'b0; end
        e.at = cyc + 4;
        q.push_back(e);
      end
      m_cnt = (ch + 1) % NCH;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 0, 0);
  endtask

  task automatic frame(input longint a0, input longint b0, input longint ar,
                       input longint br, input bit gaps);
    for (int c = 0; c < NCH; c++) begin
      if (gaps && c != 0) idle(1 + c % 2);
      issue(1'b1, c == 0, c == 0 ? a0 : ar, c == 0 ? b0 : br);
    end
  endtask

  // Monitor: every valid_o must match the oldest expected result, on the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("mprod", longint'(mprod_o), e.val);
          chk("sat", longint'(sat_o), longint'(e.sat));
          chk("latency_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_mprod", longint'(mprod_o), 0);
    chk("reset_valid", longint'(valid_o), 0);
    chk("reset_sat", longint'(sat_o), 0);
    chk("reset_err", longint'(err_o), 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    idle(2);

    frame(32'h10000, 32'h4000, 32'h10000, 32'h4000, 1'b0);   // +0x20000
    frame(-32'sh10000, 20, 32'h10000, 0, 1'b0);              // -40
    frame(AMAX, BMAX, AMAX, BMAX, 1'b0);                     // positive clip
    frame(AMIN, BMAX, AMIN, BMAX, 1'b0);                     // negative clip
    frame(1, 32'h4000, 0, 0, 1'b0);                          // rounds up to 1
    frame(-1, 32'h4000, 0, 0, 1'b0);                         // rounds to 0
    frame(32'h10000, 32'h4000, 32'h10000, 32'h4000, 1'b1);   // bubbles inside the frame
    idle(6);
    chk("err_before_abort", longint'(err_o), 0);

    issue(1'b1, 1'b1, 32'h123456, 32'h3000);
    issue(1'b1, 1'b0, 32'h123456, 32'h3000);
    frame(32'h55555, 32'h2000, -32'sh1111, 32'h7000, 1'b0);
    idle(6);
    chk("err_after_abort", longint'(err_o), longint'(m_err));
    chk("err_sticky", longint'(err_o), 1);

    issue(1'b1, 1'b1, 32'h400000, 32'h7FFF);
    issue(1'b1, 1'b0, 32'h400000, 32'h7FFF);
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset_mprod", longint'(mprod_o), 0);
    chk("midreset_valid", longint'(valid_o), 0);
    chk("midreset_sat", longint'(sat_o), 0);
    chk("midreset_err", longint'(err_o), 0);
    q.delete();
    m_cnt = 0;
    m_sum = 0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    frame(32'h20000, 32'h1000, 32'h3000, -32'sh2000, 1'b0);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      bit v, s;
      logic signed [MPCAND_W-1:0] ra;
      logic signed [MPLIER_W-1:0] rb;
      v = ($urandom_range(3) != 0);
      s = (m_cnt == 0) ? ($urandom_range(7) != 0) : ($urandom_range(19) == 0);
      ra = MPCAND_W'($urandom);
      rb = MPLIER_W'($urandom);
      case ($urandom_range(7))
        0: begin ra = MPCAND_W'(AMAX); rb = MPLIER_W'(BMAX); end
        1: begin ra = MPCAND_W'(AMIN); rb = MPLIER_W'(BMAX); end
        default: ;
      endcase
      issue(v, s, longint'(ra), longint'(rb));
    end
    idle(8);
    chk("final_err", longint'(err_o), longint'(m_err));
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
